// File: rtl/ws2812_pkg.sv
// ws2812_pkg: shared types and 25 MHz timing defaults for the WS2812 receiver.
package ws2812_pkg;

    typedef enum logic [1:0] {ST_SYNC, ST_IDLE, ST_HIGH, ST_LOW} state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'd0,
        CAUSE_GLITCH  = 2'd1,
        CAUSE_STUCK   = 2'd2,
        CAUSE_PARTIAL = 2'd3
    } err_cause_e;

    localparam int T0H          = 10;
    localparam int T1H          = 20;
    localparam int TBIT         = 32;
    localparam int RESET_CYCLES = 1250;

    function automatic int cnt_width(input int max_cnt);
        return $clog2(max_cnt + 1);
    endfunction

endpackage

// File: rtl/ws2812_pulse_meter.sv
// ws2812_pulse_meter: synchronizes din, detects edges and measures high/low run lengths.
module ws2812_pulse_meter
    import ws2812_pkg::*;
#(
    parameter int RESET_CYCLES = ws2812_pkg::RESET_CYCLES,
    parameter int CNT_W        = cnt_width(ws2812_pkg::RESET_CYCLES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    output logic             rise,
    output logic             fall,
    output logic             latch,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] low_cnt
);

    localparam logic [CNT_W-1:0] SAT = CNT_W'(RESET_CYCLES);

    logic [1:0]       sync_q;
    logic             din_s;
    logic             din_d_q;
    logic             latch_q;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] low_q, low_d;

    assign din_s    = sync_q[1];
    assign rise     = din_s & ~din_d_q;
    assign fall     = ~din_s & din_d_q;
    assign latch    = latch_q;
    assign high_cnt = high_q;
    assign low_cnt  = low_q;

    always_comb begin
        high_d = fall ? '0 : (din_s && high_q != SAT) ? high_q + CNT_W'(1) : high_q;
        low_d  = rise ? '0 : (!din_s && low_q != SAT) ? low_q + CNT_W'(1) : low_q;
    end

    // latch is a one-shot on the cycle the low counter first saturates
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            din_d_q <= 1'b0;
            high_q  <= '0;
            low_q   <= '0;
            latch_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], din};
            din_d_q <= din_s;
            high_q  <= high_d;
            low_q   <= low_d;
            latch_q <= (low_d == SAT) && (low_q != SAT);
        end
    end

endmodule

// File: rtl/ws2812_rx.sv
// ws2812_rx: decodes a WS2812 serial stream into indexed 24-bit GRB pixels with frame-end strobes.
// Define WS2812_RX_ERR_EN to drop glitches and report glitch/stuck-high/partial-pixel errors.
module ws2812_rx
    import ws2812_pkg::*;
#(
    parameter int BIT_THRESH   = 15,
    parameter int MIN_HIGH     = 4,
    parameter int RESET_CYCLES = ws2812_pkg::RESET_CYCLES,
    parameter int ADDR_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din,
    output logic [23:0]       pixel_data,
    output logic [ADDR_W-1:0] pixel_addr,
    output logic              pixel_valid,
    output logic              frame_done,
    output logic              err,
    output logic [1:0]        err_cause
);

    localparam int CNT_W = cnt_width(RESET_CYCLES);
    localparam logic [CNT_W-1:0] SAT    = CNT_W'(RESET_CYCLES);
    localparam logic [CNT_W-1:0] THRESH = CNT_W'(BIT_THRESH);
    localparam logic [CNT_W-1:0] GLITCH = CNT_W'(MIN_HIGH);
`ifdef WS2812_RX_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic             rise, fall, latch, stuck, glitch;
    logic [CNT_W-1:0] high_cnt, low_cnt;
    state_e           state_q;
    err_cause_e       err_cause_q;
    logic [23:0]      shreg_q, word, pixel_data_q;
    logic [4:0]       bit_cnt_q;
    logic [ADDR_W-1:0] addr_next_q, pixel_addr_q;
    logic             pixel_valid_q, frame_done_q, err_q;

    ws2812_pulse_meter #(
        .RESET_CYCLES(RESET_CYCLES),
        .CNT_W       (CNT_W)
    ) u_meter (
        .clk     (clk),
        .rst     (rst),
        .din     (din),
        .rise    (rise),
        .fall    (fall),
        .latch   (latch),
        .high_cnt(high_cnt),
        .low_cnt (low_cnt)
    );

    // a sub-MIN_HIGH pulse always decodes as 0; with errors enabled it is dropped instead
    assign stuck  = high_cnt == SAT;
    assign glitch = high_cnt < GLITCH;
    assign word   = {shreg_q[22:0], !glitch && high_cnt >= THRESH};

    assign pixel_data  = pixel_data_q;
    assign pixel_addr  = pixel_addr_q;
    assign pixel_valid = pixel_valid_q;
    assign frame_done  = frame_done_q;
    assign err         = err_q;
    assign err_cause   = err_cause_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_SYNC;
            shreg_q       <= '0;
            bit_cnt_q     <= '0;
            addr_next_q   <= '0;
            pixel_data_q  <= '0;
            pixel_addr_q  <= '0;
            pixel_valid_q <= 1'b0;
            frame_done_q  <= 1'b0;
            err_q         <= 1'b0;
            err_cause_q   <= CAUSE_NONE;
        end else begin
            pixel_valid_q <= 1'b0;
            frame_done_q  <= 1'b0;
            err_q         <= 1'b0;
            case (state_q)
                ST_SYNC: begin
                    bit_cnt_q   <= '0;
                    addr_next_q <= '0;
                    if (low_cnt == SAT) state_q <= ST_IDLE;
                end
                ST_IDLE: if (rise) state_q <= ST_HIGH;
                ST_HIGH: begin
                    if (stuck) begin
                        state_q <= ST_SYNC;
                        if (ERR_EN) begin
                            err_q       <= 1'b1;
                            err_cause_q <= CAUSE_STUCK;
                        end
                    end else if (fall) begin
                        state_q <= ST_LOW;
                        if (ERR_EN && glitch) begin
                            err_q       <= 1'b1;
                            err_cause_q <= CAUSE_GLITCH;
                        end else begin
                            shreg_q <= word;
                            if (bit_cnt_q == 5'd23) begin
                                pixel_data_q  <= word;
                                pixel_addr_q  <= addr_next_q;
                                pixel_valid_q <= 1'b1;
                                addr_next_q   <= addr_next_q + ADDR_W'(1);
                                bit_cnt_q     <= '0;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 5'd1;
                            end
                        end
                    end
                end
                ST_LOW: begin
                    if (latch) begin
                        if (ERR_EN && bit_cnt_q != '0) begin
                            err_q       <= 1'b1;
                            err_cause_q <= CAUSE_PARTIAL;
                        end
                        frame_done_q <= addr_next_q != '0;
                        bit_cnt_q    <= '0;
                        addr_next_q  <= '0;
                        state_q      <= rise ? ST_HIGH : ST_IDLE;
                    end else if (rise) begin
                        state_q <= ST_HIGH;
                    end
                end
                default: state_q <= ST_SYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812_rx.sv
// tb_ws2812_rx: randomized directed scenarios for ws2812_rx checked against a frame-level model.
module tb_ws2812_rx;

    localparam int R = 1250;
`ifdef WS2812_RX_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        din = 1'b0;
    logic [23:0] pixel_data;
    logic [15:0] pixel_addr;
    logic        pixel_valid, frame_done, err;
    logic [1:0]  err_cause;

    ws2812_rx dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .pixel_data (pixel_data),
        .pixel_addr (pixel_addr),
        .pixel_valid(pixel_valid),
        .frame_done (frame_done),
        .err        (err),
        .err_cause  (err_cause)
    );

    always #20 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [39:0] obs_pix[$];
    int          obs_err[$];
    int          obs_fd = 0, obs_collide = 0, fd_cyc = 0, pv_cyc = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (pixel_valid) begin
                obs_pix.push_back({pixel_addr, pixel_data});
                pv_cyc = cyc;
            end
            if (frame_done) begin
                obs_fd++;
                fd_cyc = cyc;
            end
            if (err) obs_err.push_back(int'(err_cause));
            if (pixel_valid && frame_done) obs_collide++;
        end
    end

    // frame-level reference: bits accumulate into words, latches close frames
    logic [39:0] exp_pix[$];
    int          exp_err[$];
    int          exp_fd = 0;
    int          m_bits = 0, m_addr = 0, last_fall = 0;
    logic [23:0] m_word = '0;
    bit          m_sync = 1'b0;
    int          n_cmp = 0, n_fail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_bit(input bit b);
        if (m_sync) begin
            m_word = {m_word[22:0], b};
            m_bits++;
            if (m_bits == 24) begin
                exp_pix.push_back({16'(m_addr), m_word});
                m_addr = (m_addr + 1) % 65536;
                m_bits = 0;
            end
        end
    endtask

    task automatic m_latch();
        if (!m_sync) m_sync = 1'b1;
        else begin
            if (m_bits != 0 && ERR_EN) exp_err.push_back(3);
            if (m_addr != 0) exp_fd++;
        end
        m_bits = 0;
        m_addr = 0;
    endtask

    task automatic m_abort(input int cause);
        if (m_sync && ERR_EN && cause != 0) exp_err.push_back(cause);
        m_sync = 1'b0;
        m_bits = 0;
        m_addr = 0;
    endtask

    task automatic hold(input bit v, input int n);
        din = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input int hi, input int lo);
        hold(1'b1, hi);
        last_fall = cyc;
        hold(1'b0, lo);
    endtask

    task automatic send_bit(input bit b);
        pulse(b ? $urandom_range(19, 17) : $urandom_range(9, 6), $urandom_range(4, 2));
        m_bit(b);
    endtask

    task automatic send_px(input logic [23:0] w);
        for (int i = 23; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic do_latch();
        hold(1'b0, 1300);
        m_latch();
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".npix"}, obs_pix.size(), exp_pix.size());
        for (int i = 0; i < exp_pix.size() && i < obs_pix.size(); i++)
            check($sformatf("%s.pix%0d", tag, i), obs_pix[i], exp_pix[i]);
        check({tag, ".frame_done"}, obs_fd, exp_fd);
        check({tag, ".nerr"}, obs_err.size(), exp_err.size());
        for (int i = 0; i < exp_err.size() && i < obs_err.size(); i++)
            check($sformatf("%s.err%0d", tag, i), obs_err[i], exp_err[i]);
        check({tag, ".collide"}, obs_collide, 0);
        obs_pix.delete();
        exp_pix.delete();
        obs_err.delete();
        exp_err.delete();
        obs_fd = 0;
        exp_fd = 0;
        obs_collide = 0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".data"}, pixel_data, 0);
        check({tag, ".addr"}, pixel_addr, 0);
        check({tag, ".valid"}, pixel_valid, 0);
        check({tag, ".fd"}, frame_done, 0);
        check({tag, ".err"}, err, 0);
        check({tag, ".cause"}, err_cause, 0);
    endtask

    initial begin
        #(40 * 150000);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1);
    end

    initial begin
        logic [23:0] w;
        repeat (3) @(negedge clk);
        check_reset("por");
        rst = 1'b0;

        // single known pixel with nominal widths, plus latency checks
        do_latch();
        w = 24'hFF0000;
        for (int i = 23; i >= 0; i--) begin
            if (w[i]) pulse(20, 12); else pulse(10, 22);
            m_bit(w[i]);
        end
        do_latch();
        check("single.pv_lat", (pv_cyc - last_fall) inside {[2:5]}, 1);
        check("single.fd_lat", (fd_cyc - last_fall) inside {[R + 2:R + 4]}, 1);
        compare_all("single");

        // 150-pixel ramp, then a short second frame restarting at addr 0
        for (int p = 0; p < 150; p++) send_px(24'(p * 32'h050505));
        do_latch();
        compare_all("ramp");
        for (int p = 0; p < 3; p++) send_px(24'($urandom()));
        do_latch();
        compare_all("frame2");

        // partial pixel at latch
        for (int i = 0; i < 10; i++) send_bit(1'($urandom()));
        do_latch();
        compare_all("partial");

        // short glitch inside a pixel
        for (int i = 0; i < 12; i++) send_bit(1'($urandom()));
        hold(1'b1, 2);
        hold(1'b0, $urandom_range(6, 4));
        if (ERR_EN) exp_err.push_back(1); else m_bit(1'b0);
        for (int i = 0; i < 12; i++) send_bit(1'($urandom()));
        do_latch();
        compare_all("glitch");

        // stuck-high mid-frame, resync, then one pixel at addr 0
        send_px(24'($urandom()));
        for (int i = 0; i < 8; i++) send_bit(1'($urandom()));
        hold(1'b1, 1300);
        m_abort(2);
        do_latch();
        send_px(24'($urandom()));
        do_latch();
        compare_all("stuck");

        // reset during bit 12, stray bits ignored until a full latch
        send_px(24'($urandom()) | 24'h800001);
        for (int i = 0; i < 11; i++) send_bit(1'($urandom()));
        hold(1'b1, 5);
        rst = 1'b1;
        m_abort(0);
        repeat (2) @(negedge clk);
        check_reset("midrst");
        rst = 1'b0;
        hold(1'b1, 5);
        hold(1'b0, 3);
        for (int i = 0; i < 6; i++) send_bit(1'($urandom()));
        do_latch();
        send_px(24'($urandom()));
        do_latch();
        compare_all("rstrec");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ws2812_rx.md
# ws2812_rx

Receive-side decoder for the single-wire WS2812 (NeoPixel) LED stream that the neopixel transmitter produces. It samples the serial line, classifies each high pulse as a 0 or 1 bit, and assembles 24-bit pixel words in GRB order. It emits one pixel per strobe with its index within the frame, and marks frame ends at latch (long-low) intervals. It serves as a loopback checker beside the transmitter on the same 25 MHz fabric clock, and as the input stage of daisy-chained boards.

## Interface
- `BIT_THRESH`, 15: high-pulse width in clk cycles at or above which a bit decodes as 1 (T0H ≈ 10, T1H ≈ 20 cycles @ 25 MHz).
- `MIN_HIGH`, 4: high pulses shorter than this are glitches. Only used with the error feature.
- `RESET_CYCLES`, 1250: continuous low that constitutes latch/frame end (50 µs @ 25 MHz).
- `ADDR_W`, 16: width of the pixel index.
- `clk`  in  1: fabric clock. One clock domain.
- `rst`  in  1: synchronous, active-high reset.
- `din`  in  1: asynchronous WS2812 serial line.
- `pixel_data`  out  24: last completed pixel. First received bit is at [23]; [23:16]=G, [15:8]=R, [7:0]=B.
- `pixel_addr`  out  ADDR_W: index of `pixel_data` within the current frame, starting at 0.
- `pixel_valid`  out  1: one-cycle strobe; data and address are valid on the same cycle.
- `frame_done`  out  1: one-cycle strobe at latch detection, only if ≥1 pixel was received in the frame.
- `err`  out  1: one-cycle error strobe.
- `err_cause`  out  2: 0 none, 1 glitch, 2 stuck-high, 3 partial pixel. Held until the next `err`.

## Operation
- `din` passes through a 2-flop synchronizer to produce `din_s`, then a 1-flop delay to produce `din_d`. Rise = `din_s & ~din_d`; fall = `~din_s & din_d`.
- `high_cnt` counts cycles with `din_s`=1. `low_cnt` counts cycles with `din_s`=0. Both saturate at `RESET_CYCLES`. Each clears on the opposite edge.
- States:
  - SYNC: entered from reset. Ignores all pulses. Moves to IDLE once `low_cnt` reaches `RESET_CYCLES`.
  - IDLE: line low between frames. On rise, go to HIGH.
  - HIGH: on fall, decode the bit as `high_cnt >= BIT_THRESH`, shift it into the 24-bit register MSB-first, increment `bit_cnt`, go to LOW. If `high_cnt` reaches `RESET_CYCLES`, it is stuck-high: go to SYNC and discard the partial word.
  - LOW: on rise, go to HIGH. If `low_cnt` reaches `RESET_CYCLES`, latch:
    - if `bit_cnt` ≠ 0, discard the partial word (cause 3);
    - pulse `frame_done` if `pixel_addr_next` ≠ 0;
    - clear `bit_cnt` and `pixel_addr_next`;
    - go to IDLE.
- When the 24th bit is shifted:
  - register the word to `pixel_data` and `pixel_addr_next` to `pixel_addr`;
  - pulse `pixel_valid`;
  - increment `pixel_addr_next`, wrapping mod 2^ADDR_W;
  - clear `bit_cnt`.
- Back-to-back pixels need no gap. The next bit's rise may arrive on the cycle after `pixel_valid`.
- Reset values: `pixel_data`=0, `pixel_addr`=0, `pixel_valid`=0, `frame_done`=0, `err`=0, `err_cause`=0. State = SYNC; all counters 0.
- `rst` asserted mid-frame aborts immediately. No strobe is emitted for the partial word. The block must see a full latch before accepting data again.

## Timing
- `pixel_valid` rises 3 clk edges after the first edge that samples `din` low at the end of the 24th bit: 2 synchronizer edges plus 1 output register.
- `frame_done` rises on the cycle after `low_cnt` reaches `RESET_CYCLES`, i.e. `RESET_CYCLES`+3 cycles after the last `din` fall.
- `pixel_valid` and `frame_done` are never asserted in the same cycle.
- Decoded width equals the synchronized high width, within ±1 cycle of the true width.

## Configuration
- `WS2812_RX_ERR_EN` defined:
  - a high pulse with `high_cnt < MIN_HIGH` is dropped (not shifted) and strobes `err` with cause 1;
  - stuck-high strobes `err` with cause 2;
  - partial pixel at latch strobes `err` with cause 3.
- Undefined:
  - glitches decode as 0 bits;
  - stuck-high and partial-pixel handling still occur, silently;
  - `err` and `err_cause` are tied to 0;
  - `MIN_HIGH` is unused.

## Structure
- Package `ws2812_pkg`: state enum (SYNC/IDLE/HIGH/LOW), err_cause codes, default timing constants for 25 MHz (`T0H`=10, `T1H`=20, `TBIT`=32, `RESET_CYCLES`=1250).
- Sub-module `ws2812_pulse_meter`: synchronizer, edge detect, and saturating high/low counters. Outputs rise, fall, `high_cnt`, `low_cnt`, and `latch`. `ws2812_rx` holds the FSM, shifter and address logic.

## Test plan
- 1300 low, then 24 bits of 0xFF0000 (eight 20H/12L, sixteen 10H/22L), then 1300 low → `pixel_valid` once with data 0xFF0000, addr 0; then `frame_done` once.
- 1300 low, then 150 pixels from 0x000000 incrementing by 0x050505 (the transmitter's ramp), then latch → 150 strobes, addr 0..149, data matching; one `frame_done`. A second frame restarts at addr 0.
- 1300 low, then 10 valid bits, then latch → no `pixel_valid`, no `frame_done`. With the macro: `err` with cause 3.
- 1300 low, then a 2-cycle high pulse inside a pixel → with the macro, the pulse is dropped and `err` fires with cause 1; without it, a 0 bit is inserted and the word shifts.
- `din` held high 1300 cycles mid-frame, then 1300 low, then one valid pixel → no strobe for the aborted word; with the macro, cause 2; the subsequent pixel decodes at addr 0.
- `rst` pulsed during bit 12 of a pixel → all outputs 0. Bits arriving before a full latch are ignored. After 1250 low, the next pixel decodes correctly.
